// File: rtl/alu_mdu_pkg.sv
// Purpose : shared op codes and FSM state encoding for the EX-stage ALU and multiply/divide unit.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package alu_mdu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_OR    = 4'd2,
      ALU_LUI   = 4'd3,
      ALU_PASSA = 4'd4,
      ALU_AND   = 4'd5,
      ALU_XOR   = 4'd6,
      ALU_NOR   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_SLL   = 4'd10,
      ALU_SRL   = 4'd11,
      ALU_SRA   = 4'd12
   } alu_op_e;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Only codes 1..4 launch a multi-cycle operation.
   function automatic logic is_md_launch(input logic [3:0] op);
      return (op >= 4'(MD_MULT)) && (op <= 4'(MD_DIVU));
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Purpose : EX-stage operand/result bundle between the pipeline controller and alu_mdu.
// Latency : n/a (wiring only).
// Backpressure: busy tells the controller to stall EX while a mult/div is in flight.
// Signals : a, b, alu_op, md_op, start (controller -> unit); c, zero, overflow, busy, hi, lo (unit -> controller).
interface alu_mdu_if #(parameter int WIDTH = 32) ();
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_op;
   logic [3:0]       md_op;
   logic             start;
   logic [WIDTH-1:0] c;
   logic             zero;
   logic             overflow;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output a, b, alu_op, md_op, start,
      input  c, zero, overflow, busy, hi, lo
   );

   modport slave (
      input  a, b, alu_op, md_op, start,
      output c, zero, overflow, busy, hi, lo
   );
endinterface

// File: rtl/alu_mdu_core.sv
// Purpose : sequential mult/div unit with HI/LO registers, operand latches and cycle counter.
// Latency : busy for exactly MUL_CYCLES / DIV_CYCLES cycles; HI/LO update on the edge busy falls.
// Backpressure: starts while busy are dropped; mthi/mtlo are dropped while busy.
// Ports   : clk, reset (async active-low), a_i/b_i operands, md_op_i/start_i command, busy_o, hi_o, lo_o.
module mdu_core #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       md_op_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   import alu_mdu_pkg::*;

   localparam int MAXN = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;
   localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [3:0]       op_q, op_d;

   // Result datapath works on the latched operands only; it is sampled on the final RUN edge.
   logic               sgn, is_mul, neg_a, neg_b;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic [WIDTH-1:0]   mag_a, mag_b, quo_u, rem_u, quo, rem;

   always_comb begin
      sgn    = (op_q == 4'(MD_MULT)) || (op_q == 4'(MD_DIV));
      is_mul = (op_q == 4'(MD_MULT)) || (op_q == 4'(MD_MULTU));
      // Sign/zero-extending to 2*WIDTH lets one unsigned multiplier serve both mult and multu.
      ext_a  = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
      ext_b  = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
      prod   = ext_a * ext_b;
      // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
      // MIN / -1 falls out naturally as quotient MIN, remainder 0.
      neg_a  = sgn & a_q[WIDTH-1];
      neg_b  = sgn & b_q[WIDTH-1];
      mag_a  = neg_a ? (~a_q + 1'b1) : a_q;
      mag_b  = neg_b ? (~b_q + 1'b1) : b_q;
      quo_u  = (mag_b == '0) ? '0 : (mag_a / mag_b);
      rem_u  = (mag_b == '0) ? '0 : (mag_a % mag_b);
      quo    = (neg_a ^ neg_b) ? (~quo_u + 1'b1) : quo_u;
      rem    = neg_a ? (~rem_u + 1'b1) : rem_u;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i && is_md_launch(md_op_i)) begin
               a_d     = a_i;
               b_d     = b_i;
               op_d    = md_op_i;
               cnt_d   = ((md_op_i == 4'(MD_MULT)) || (md_op_i == 4'(MD_MULTU))) ? MUL_LD : DIV_LD;
               state_d = ST_RUN;
            end else if (md_op_i == 4'(MD_MTHI)) begin
               hi_d = a_i;
            end else if (md_op_i == 4'(MD_MTLO)) begin
               lo_d = a_i;
            end
         end
         ST_RUN: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (is_mul) begin
                  {hi_d, lo_d} = prod;
               end else if (b_q != '0) begin
                  // Divide by zero leaves HI/LO untouched.
                  lo_d = quo;
                  hi_d = rem;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy_o = (state_q == ST_RUN);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Purpose : EX-stage ALU (combinational) plus multi-cycle mult/div unit with HI/LO.
// Latency : ALU result, zero, overflow same cycle; mult/div per MUL_CYCLES / DIV_CYCLES.
// Backpressure: busy high while mult/div in flight; controller stalls EX on it.
// Ports   : clk, reset (async active-low), bus (alu_mdu_if slave: operands, ops, start, c, flags, busy, hi, lo).
module alu_mdu #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic      clk,
   input  logic      reset,
   alu_mdu_if.slave  bus
);
   import alu_mdu_pkg::*;

   localparam int S = $clog2(WIDTH);
   localparam int M = WIDTH - 1;

   logic [S-1:0]     shamt;
   logic [WIDTH-1:0] sum, diff, alu_res;
   logic             ovf;

   always_comb begin
      shamt   = bus.a[S-1:0];
      sum     = bus.a + bus.b;
      diff    = bus.a - bus.b;
      alu_res = '0;
      ovf     = 1'b0;
      case (bus.alu_op)
         ALU_ADD: begin
            alu_res = sum;
            ovf     = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
         end
         ALU_SUB: begin
            alu_res = diff;
            ovf     = (bus.a[M] != bus.b[M]) && (diff[M] != bus.a[M]);
         end
         ALU_OR:    alu_res = bus.a | bus.b;
         ALU_LUI:   alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         ALU_PASSA: alu_res = bus.a;
         ALU_AND:   alu_res = bus.a & bus.b;
         ALU_XOR:   alu_res = bus.a ^ bus.b;
         ALU_NOR:   alu_res = ~(bus.a | bus.b);
         ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         // Shifts move b by the low S bits of a (rs carries the shift amount).
         ALU_SLL:   alu_res = bus.b << shamt;
         ALU_SRL:   alu_res = bus.b >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(bus.b) >>> shamt);
         default:   alu_res = '0;
      endcase
   end

   // mfhi/mflo take priority over the ALU and show the committed registers.
   assign bus.c        = (bus.md_op == 4'(MD_MFHI)) ? bus.hi :
                         (bus.md_op == 4'(MD_MFLO)) ? bus.lo : alu_res;
   assign bus.zero     = (bus.a == bus.b);
   assign bus.overflow = ovf;

   mdu_core #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .a_i     (bus.a),
      .b_i     (bus.b),
      .md_op_i (bus.md_op),
      .start_i (bus.start),
      .busy_o  (bus.busy),
      .hi_o    (bus.hi),
      .lo_o    (bus.lo)
   );

endmodule

// File: tb/tb_alu_mdu.sv
// Purpose : directed self-checking bench for alu_mdu at WIDTH=32 and WIDTH=16/MUL_CYCLES=1.
// Latency : inputs driven on falling edge, outputs sampled on falling edge (+1 for combinational paths).
// Backpressure: busy counted per cycle against the expected MUL/DIV cycle counts.
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_mdu_if #(.WIDTH(32)) b32 ();
   alu_mdu_if #(.WIDTH(16)) b16 ();

   alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut32 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b32)
   );

   alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut16 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b16)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic alu32(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_c, input logic exp_ov);
      @(negedge clk);
      b32.alu_op = op;
      b32.a      = a;
      b32.b      = b;
      #1;
      check(tag, b32.c, exp_c);
      check({tag, "_ov"}, b32.overflow, exp_ov);
   endtask

   // Launch an op, scramble the operands after the start cycle, count busy cycles.
   task automatic md32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
      @(negedge clk);
      b32.md_op = op;
      b32.a     = a;
      b32.b     = b;
      b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0;
      b32.md_op = MD_NONE;
      b32.a     = 32'hDEAD_BEEF;
      b32.b     = 32'h0;
      cyc = 0;
      while (b32.busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic mv32(input logic [3:0] op, input logic [31:0] a);
      @(negedge clk);
      b32.md_op = op;
      b32.a     = a;
      @(negedge clk);
      b32.md_op = MD_NONE;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n = 1'b0;
      b32.a = '0; b32.b = '0; b32.alu_op = '0; b32.md_op = '0; b32.start = 1'b0;
      b16.a = '0; b16.b = '0; b16.alu_op = '0; b16.md_op = '0; b16.start = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", b32.busy, 0);
      check("rst_hi", b32.hi, 0);
      check("rst_lo", b32.lo, 0);
      rst_n = 1'b1;

      // Combinational ALU
      alu32("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
      alu32("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
      alu32("add_plain", ALU_ADD, 32'h5, 32'h3, 32'h8, 1'b0);
      alu32("sra", ALU_SRA, 32'h4, 32'hF000_0000, 32'hFF00_0000, 1'b0);
      alu32("srl", ALU_SRL, 32'h4, 32'hF000_0000, 32'h0F00_0000, 1'b0);
      alu32("sll", ALU_SLL, 32'h24, 32'h1, 32'h10, 1'b0);
      alu32("sltu", ALU_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0);
      alu32("slt", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0);
      alu32("lui", ALU_LUI, 32'h0, 32'hABCD_1234, 32'h1234_0000, 1'b0);
      alu32("nor", ALU_NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00, 1'b0);
      alu32("xor", ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0);
      alu32("op13", 4'd13, 32'h1234, 32'h5678, 32'h0, 1'b0);
      check("zero_ne", b32.zero, 0);
      alu32("and_eq", ALU_AND, 32'h5A5A, 32'h5A5A, 32'h5A5A, 1'b0);
      check("zero_eq", b32.zero, 1);

      // Multiply
      md32(MD_MULT, 32'hFFFF_FFFF, 32'h2, cyc);
      check("mult_cyc", cyc, 5);
      check("mult_hi", b32.hi, 32'hFFFF_FFFF);
      check("mult_lo", b32.lo, 32'hFFFF_FFFE);
      md32(MD_MULTU, 32'hFFFF_FFFF, 32'h2, cyc);
      check("multu_cyc", cyc, 5);
      check("multu_hi", b32.hi, 32'h1);
      check("multu_lo", b32.lo, 32'hFFFF_FFFE);

      // Divide
      md32(MD_DIV, 32'hFFFF_FFF9, 32'h2, cyc);
      check("div_cyc", cyc, 10);
      check("div_lo", b32.lo, 32'hFFFF_FFFD);
      check("div_hi", b32.hi, 32'hFFFF_FFFF);
      md32(MD_DIVU, 32'h7, 32'h0, cyc);
      check("divz_cyc", cyc, 10);
      check("divz_lo", b32.lo, 32'hFFFF_FFFD);
      check("divz_hi", b32.hi, 32'hFFFF_FFFF);
      md32(MD_DIVU, 32'd100, 32'd7, cyc);
      check("divu_lo", b32.lo, 32'd14);
      check("divu_hi", b32.hi, 32'd2);
      md32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      check("divmin_lo", b32.lo, 32'h8000_0000);
      check("divmin_hi", b32.hi, 32'h0);

      // Start and mthi while busy are ignored; mflo returns the committed value
      @(negedge clk);
      b32.md_op = MD_MULT; b32.a = 32'd3; b32.b = 32'd5; b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0; b32.md_op = MD_NONE; b32.alu_op = ALU_PASSA;
      cyc = 0;
      while (b32.busy && cyc < 100) begin
         cyc++;
         case (cyc)
            1: begin b32.md_op = MD_DIV; b32.a = 32'd100; b32.b = 32'd7; b32.start = 1'b1; end
            2: begin b32.start = 1'b0; b32.md_op = MD_MTHI; b32.a = 32'h1234; end
            3: begin
               check("busy_mthi_ign", b32.hi, 32'h0);
               b32.md_op = MD_MFLO;
               #1;
               check("mflo_busy_old", b32.c, 32'h8000_0000);
            end
            default: b32.md_op = MD_NONE;
         endcase
         @(negedge clk);
      end
      check("ovl_cyc", cyc, 5);
      check("ovl_hi", b32.hi, 32'h0);
      check("ovl_lo", b32.lo, 32'd15);
      @(negedge clk);
      check("ovl_no_div", b32.busy, 0);

      // Reset mid-run
      mv32(MD_MTHI, 32'h55);
      check("mthi_idle", b32.hi, 32'h55);
      @(negedge clk);
      b32.md_op = MD_MULT; b32.a = 32'd6; b32.b = 32'd7; b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0; b32.md_op = MD_NONE;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", b32.busy, 0);
      check("midrst_hi", b32.hi, 0);
      check("midrst_lo", b32.lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("postrst_busy", b32.busy, 0);
      check("postrst_hi", b32.hi, 0);
      check("postrst_lo", b32.lo, 0);

      // mtlo / mflo at WIDTH=32
      mv32(MD_MTLO, 32'hABCD);
      check("mtlo32", b32.lo, 32'hABCD);
      b32.md_op = MD_MFLO;
      #1;
      check("mflo32", b32.c, 32'hABCD);
      b32.md_op = MD_NONE;

      // WIDTH=16, MUL_CYCLES=1
      @(negedge clk);
      b16.md_op = MD_MTLO; b16.a = 16'hABCD;
      @(negedge clk);
      b16.md_op = MD_NONE;
      check("mtlo16", b16.lo, 16'hABCD);
      b16.md_op = MD_MFLO;
      #1;
      check("mflo16", b16.c, 16'hABCD);
      @(negedge clk);
      b16.md_op = MD_MULT; b16.a = 16'hFFFF; b16.b = 16'h2; b16.start = 1'b1;
      @(negedge clk);
      b16.start = 1'b0; b16.md_op = MD_NONE; b16.a = 16'h0; b16.b = 16'h0;
      cyc = 0;
      while (b16.busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check("mult16_cyc", cyc, 1);
      check("mult16_hi", b16.hi, 16'hFFFF);
      check("mult16_lo", b16.lo, 16'hFFFE);
      b16.alu_op = ALU_ADD; b16.a = 16'h7FFF; b16.b = 16'h1;
      #1;
      check("add16", b16.c, 16'h8000);
      check("add16_ov", b16.overflow, 1);
      @(negedge clk);
      b16.alu_op = ALU_LUI; b16.a = 16'h0; b16.b = 16'h3412;
      #1;
      check("lui16", b16.c, 16'h1200);
      @(negedge clk);
      b16.alu_op = ALU_SLL; b16.a = 16'h14; b16.b = 16'h1;
      #1;
      check("sll16", b16.c, 16'h10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
